debug_obi_slave_arbiter: RTL



---
 rtl/debug_obi_slave_arbiter_pkg.sv | 38 +++
 rtl/debug_arb_idx_fifo.sv | 88 ++++++++
 rtl/debug_obi_slave_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/debug_obi_slave_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_obi_slave_arbiter_pkg                                     |
// | Purpose  : OBI request/response types and the index-width helper used by   |
// |            the debug-module slave-port arbiter and its index FIFO.         |
// | Contents : obi_req_t  (req, we, addr, be, wdata)                           |
// |            obi_resp_t (gnt, rvalid, rdata)                                 |
// |            idx_width() : bits needed to index n entries (minimum 1)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package debug_obi_slave_arbiter_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [OBI_ADDR_W-1:0] addr;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

  // A single-entry structure still needs a 1-bit index so that ports and
  // pointers never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_arb_idx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_arb_idx_fifo                                              |
// | Purpose  : Small synchronous FIFO holding the hart index of every          |
// |            transaction granted by the debug slave port but not yet         |
// |            answered. Wrapping read/write pointers plus an occupancy count  |
// |            make any depth legal, including non powers of two.             |
// | Ports    : clk_i, rst_ni (sync, active-low)                                |
// |            push/data_in : append an entry (ignored when full)              |
// |            pop          : drop the head entry (ignored when empty)         |
// |            head         : oldest entry                                     |
// |            full, empty, count : occupancy status                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module debug_arb_idx_fifo
  import debug_obi_slave_arbiter_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  parameter  int unsigned Width = 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PTR_W = idx_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wrap_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = wrap_inc(rd_ptr_q);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_obi_slave_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_obi_slave_arbiter                                         |
// | Purpose  : Round-robin OBI arbiter sharing the single debug-module slave   |
// |            port between NrHarts requesters. A stalled selection is locked  |
// |            until granted, granted transactions are tracked in an index     |
// |            FIFO and each rvalid/rdata is routed back to its issuing hart.  |
// | Ports    : clk_i, rst_ni (sync, active-low)                                |
// |            hart_req_i / hart_resp_o : per-hart OBI request / response      |
// |            dm_req_o / dm_resp_i     : debug-module slave port              |
// |            err_o  : sticky, rvalid seen with nothing outstanding           |
// |            busy_o : lock held or transactions outstanding                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module debug_obi_slave_arbiter
  import debug_obi_slave_arbiter_pkg::*;
#(
  parameter  int unsigned NrHarts        = 2,
  parameter  int unsigned MaxOutstanding = 2,
  localparam int unsigned IdxW           = idx_width(NrHarts)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t  [NrHarts-1:0] hart_req_i,
  output obi_resp_t [NrHarts-1:0] hart_resp_o,
  output obi_req_t                dm_req_o,
  input  obi_resp_t               dm_resp_i,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  locked_idx_q, locked_idx_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic [IdxW-1:0]  sel;
  logic             sel_valid;
  logic             fwd;
  logic             sel_req;
  logic             handshake;
  logic             do_pop;
  logic [IdxW-1:0]  fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Selection: the locked hart wins unconditionally; otherwise the first
  // requesting hart at or after the priority pointer, wrapping around.
  always_comb begin : p_select
    int unsigned cand;
    cand      = 0;
    sel       = '0;
    sel_valid = 1'b0;
    if (locked_q) begin
      sel       = locked_idx_q;
      sel_valid = 1'b1;
    end else begin
      for (int unsigned off = 0; off < NrHarts; off++) begin
        cand = 32'(ptr_q) + off;
        if (cand >= NrHarts) cand = cand - NrHarts;
        if (!sel_valid && hart_req_i[IdxW'(cand)].req) begin
          sel       = IdxW'(cand);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // A full FIFO blocks issue even when a pop happens this cycle, which keeps
  // rvalid off the combinational path to dm_req_o.req.
  assign fwd       = rst_ni & ~fifo_full & sel_valid;
  assign sel_req   = hart_req_i[sel].req;
  assign handshake = fwd & sel_req & dm_resp_i.gnt;
  assign do_pop    = rst_ni & dm_resp_i.rvalid & ~fifo_empty;

  always_comb begin : p_route
    dm_req_o    = '0;
    hart_resp_o = '0;
    // A locked hart that dropped req is still forwarded, fields and all,
    // so the slave keeps seeing the same request once req returns.
    if (fwd) begin
      dm_req_o             = hart_req_i[sel];
      hart_resp_o[sel].gnt = dm_resp_i.gnt & sel_req;
    end
    if (do_pop) begin
      hart_resp_o[fifo_head].rvalid = 1'b1;
      hart_resp_o[fifo_head].rdata  = dm_resp_i.rdata;
    end
  end

  always_comb begin : p_next
    ptr_d        = ptr_q;
    locked_d     = locked_q;
    locked_idx_d = locked_idx_q;
    err_d        = err_q;
    if (handshake) begin
      locked_d = 1'b0;
      ptr_d    = (sel == IdxW'(NrHarts - 1)) ? '0 : sel + IdxW'(1);
    end else if (fwd && sel_req) begin
      locked_d     = 1'b1;
      locked_idx_d = sel;
    end
    if (dm_resp_i.rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      locked_q     <= 1'b0;
      locked_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      locked_q     <= locked_d;
      locked_idx_q <= locked_idx_d;
      err_q        <= err_d;
    end
  end

  debug_arb_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (handshake),
    .pop     (do_pop),
    .data_in (sel),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign err_o  = err_q;
  assign busy_o = locked_q | (fifo_count != '0);

endmodule
`default_nettype wire
